// File: rtl/fbs_pkg.sv
// ============================================================================
// Module   : fbs_pkg
// Brief    : Shared sizes and state encoding for the F-register backup system.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fbs_pkg;

    localparam int FBS_DEPTH  = 64;
    localparam int FBS_DATA_W = 256;
    localparam int FBS_FCC_W  = 16;

    localparam int              ST_W      = 3;
    localparam logic [ST_W-1:0] C_ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] C_ST_SAVE = 3'd1;
    localparam logic [ST_W-1:0] C_ST_REST = 3'd2;
    localparam logic [ST_W-1:0] C_ST_WAIT = 3'd3;
    localparam logic [ST_W-1:0] C_ST_LOAD = 3'd4;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_SAVE = C_ST_SAVE,
        ST_REST = C_ST_REST,
        ST_WAIT = C_ST_WAIT,
        ST_LOAD = C_ST_LOAD
    } fbs_state_e;

    // The latency counter only ever holds RESTORE_LAT-1, so it never needs more.
    function automatic int lat_ctr_w(input int lat);
        return (lat < 2) ? 1 : $clog2(lat);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fbs_lat_ctr.sv
// ============================================================================
// Module   : fbs_lat_ctr
// Brief    : Loadable down-counter that times the restore read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fbs_lat_ctr
    import fbs_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] init,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= init;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/fbs_ctrl.sv
// ============================================================================
// Module   : fbs_ctrl
// Brief    : Call/return sequencer feeding backup/restore pulses to fbs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fbs_ctrl
    import fbs_pkg::*;
#(
    parameter int DEPTH       = FBS_DEPTH,
    parameter int RESTORE_LAT = 1,
    parameter int DATA_W      = FBS_DATA_W,
    parameter int FCC_W       = FBS_FCC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [DATA_W-1:0] restore_data,
    input  logic [FCC_W-1:0]  fcc,
    output logic              backup,
    output logic              restore,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_load,
    output logic              req_ack,
    output logic              stall,
    output logic [FCC_W-1:0]  depth,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              sync_err
);

    localparam int                LAT_W      = lat_ctr_w(RESTORE_LAT);
    localparam logic [LAT_W-1:0]  C_LAT_INIT = LAT_W'(RESTORE_LAT - 1);
    localparam logic [FCC_W-1:0]  C_FULL     = FCC_W'(DEPTH);

    fbs_state_e        state_q;
    logic [FCC_W-1:0]  depth_q;
    logic [DATA_W-1:0] rf_data_q;
    logic              backup_q;
    logic              restore_q;
    logic              rf_load_q;
    logic              req_ack_q;
    logic              ovf_q;
    logic              unf_q;
    logic              sync_q;

    logic              w_lat_load;
    logic              w_lat_done;

    assign w_lat_load = (state_q == ST_REST);

    fbs_lat_ctr #(
        .W (LAT_W)
    ) u_lat_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (w_lat_load),
        .init  (C_LAT_INIT),
        .done  (w_lat_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            depth_q   <= '0;
            rf_data_q <= '0;
            backup_q  <= 1'b0;
            restore_q <= 1'b0;
            rf_load_q <= 1'b0;
            req_ack_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            backup_q  <= 1'b0;
            restore_q <= 1'b0;
            rf_load_q <= 1'b0;
            req_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fcc != depth_q) begin
                        sync_q <= 1'b1;
                    end
                    // An error ack is issued from IDLE; the still-held request
                    // in that ack cycle belongs to the refused transaction.
                    if (!req_ack_q) begin
                        if (call_req) begin
                            req_ack_q <= 1'b1;
                            if (depth_q == C_FULL) begin
                                ovf_q <= 1'b1;
                            end else begin
                                backup_q <= 1'b1;
                                state_q  <= ST_SAVE;
                            end
                        end else if (ret_req) begin
                            if (depth_q == '0) begin
                                unf_q     <= 1'b1;
                                req_ack_q <= 1'b1;
                            end else begin
                                restore_q <= 1'b1;
                                state_q   <= ST_REST;
                            end
                        end
                    end
                end
                ST_SAVE: begin
                    depth_q <= depth_q + 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_REST: begin
                    depth_q <= depth_q - 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_lat_done) begin
                        rf_data_q <= restore_data;
                        rf_load_q <= 1'b1;
                        req_ack_q <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall    = (state_q != ST_IDLE) | call_req | ret_req;
    assign backup   = backup_q;
    assign restore  = restore_q;
    assign rf_data  = rf_data_q;
    assign rf_load  = rf_load_q;
    assign req_ack  = req_ack_q;
    assign depth    = depth_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;
    assign sync_err = sync_q;

endmodule

`default_nettype wire
